// File: rtl/mul_pkg.sv
// rtl/mul_pkg.sv - shared FSM state and Booth op encodings for the sequential multiplier
package mul_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    typedef enum logic [1:0] {
        BOOTH_NOP = 2'd0,
        BOOTH_ADD = 2'd1,
        BOOTH_SUB = 2'd2
    } booth_op_e;

    // Radix-2 recoding of the multiplier pair {Q[0], q_m1}
    function automatic booth_op_e booth_decode(input logic q0, input logic q_m1);
        case ({q0, q_m1})
            2'b10:   booth_decode = BOOTH_SUB;
            2'b01:   booth_decode = BOOTH_ADD;
            default: booth_decode = BOOTH_NOP;
        endcase
    endfunction

endpackage

// File: rtl/booth_step.sv
// rtl/booth_step.sv - one combinational Booth add/sub followed by an arithmetic right shift
//
// Ports:
//   a         in   WIDTH+2  partial-product accumulator
//   q         in   WIDTH+1  multiplier register (consumed LSB first)
//   q_m1      in   1        bit shifted out of q on the previous step
//   m         in   WIDTH+1  extended multiplicand
//   next_a    out  WIDTH+2  accumulator after add/sub and shift
//   next_q    out  WIDTH+1  multiplier register after shift
//   next_q_m1 out  1        new q_m1 (old q[0])
module booth_step
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH+1:0] a,
    input  logic [WIDTH:0]   q,
    input  logic             q_m1,
    input  logic [WIDTH:0]   m,
    output logic [WIDTH+1:0] next_a,
    output logic [WIDTH:0]   next_q,
    output logic             next_q_m1
);

    booth_op_e        op;
    logic [WIDTH+1:0] m_ext;
    logic [WIDTH+1:0] sum;

    assign op    = booth_decode(q[0], q_m1);
    // One extra sign bit keeps -M representable when M is the most-negative value
    assign m_ext = {m[WIDTH], m};

    always_comb begin
        sum = a;
        case (op)
            BOOTH_ADD: sum = a + m_ext;
            BOOTH_SUB: sum = a - m_ext;
            default:   sum = a;
        endcase
    end

    // Arithmetic shift right of the concatenation {sum, q, q_m1}
    assign next_a    = {sum[WIDTH+1], sum[WIDTH+1:1]};
    assign next_q    = {sum[0], q[WIDTH:1]};
    assign next_q_m1 = q[0];

endmodule

// File: rtl/seq_booth_multiplier.sv
// rtl/seq_booth_multiplier.sv - iterative radix-2 Booth multiplier, one step per clock
//
// Ports:
//   clk          in   1        system clock, rising edge
//   rst          in   1        asynchronous active-high reset
//   start        in   1        request, sampled when not busy
//   signed_mode  in   1        1: two's-complement operands, 0: unsigned
//   a            in   WIDTH    multiplicand
//   b            in   WIDTH    multiplier
//   busy         out  1        operation in progress
//   done         out  1        one-cycle pulse, product valid
//   product      out  2*WIDTH  result, held until the next completion
module seq_booth_multiplier
    import mul_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 start,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CW = $clog2(WIDTH + 1);

    state_e           state;
    logic [CW-1:0]    cnt;
    logic [WIDTH:0]   m_reg;
    logic [WIDTH:0]   q_reg;
    logic [WIDTH+1:0] acc;
    logic             q_m1;

    logic [WIDTH+1:0] nxt_acc;
    logic [WIDTH:0]   nxt_q;
    logic             nxt_q_m1;

    // Unsigned operands get a zero MSB, so the signed Booth datapath stays exact for them
    function automatic logic [WIDTH:0] extend(input logic [WIDTH-1:0] x, input logic sm);
        extend = {sm & x[WIDTH-1], x};
    endfunction

    booth_step #(.WIDTH(WIDTH)) u_step (
        .a         (acc),
        .q         (q_reg),
        .q_m1      (q_m1),
        .m         (m_reg),
        .next_a    (nxt_acc),
        .next_q    (nxt_q),
        .next_q_m1 (nxt_q_m1)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            m_reg   <= '0;
            q_reg   <= '0;
            acc     <= '0;
            q_m1    <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            product <= '0;
        end else begin
            case (state)
                ST_IDLE, ST_DONE: begin
                    done <= 1'b0;
                    if (start) begin
                        m_reg <= extend(a, signed_mode);
                        q_reg <= extend(b, signed_mode);
                        acc   <= '0;
                        q_m1  <= 1'b0;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        state <= ST_RUN;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_RUN: begin
                    acc  <= nxt_acc;
                    q_reg <= nxt_q;
                    q_m1 <= nxt_q_m1;
                    cnt  <= cnt + 1'b1;
                    // WIDTH+1 steps cover the extended multiplier
                    if (cnt == CW'(WIDTH)) begin
                        product <= {nxt_acc[WIDTH-2:0], nxt_q};
                        busy    <= 1'b0;
                        done    <= 1'b1;
                        state   <= ST_DONE;
                    end
                end
                default: begin
                    busy  <= 1'b0;
                    done  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_booth_multiplier.sv
// tb/tb_seq_booth_multiplier.sv - directed self-checking bench for seq_booth_multiplier
module tb_seq_booth_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        signed_mode = 1'b0;
    logic [31:0] a = '0;
    logic [31:0] b = '0;
    logic        busy;
    logic        done;
    logic [63:0] product;

    int compared = 0;
    int mismatched = 0;
    int done_cnt = 0;

    seq_booth_multiplier #(.WIDTH(32)) dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .signed_mode (signed_mode),
        .a           (a),
        .b           (b),
        .busy        (busy),
        .done        (done),
        .product     (product)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (done) done_cnt++;

    initial begin
        #200000;
        $display("FAIL global_timeout observed=hang expected=finish");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Entered at the negedge after the accepting edge with lat=1; returns at the negedge done is seen
    task automatic wait_done(input int lat0, output int lat);
        lat = lat0;
        while (!done && lat < 200) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
    endtask

    task automatic run_op(input logic [31:0] ta, input logic [31:0] tb_v, input logic sm,
                          input logic [63:0] exp, input string tag);
        int lat;
        @(negedge clk);
        a = ta; b = tb_v; signed_mode = sm; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        a = $urandom; b = $urandom; signed_mode = ~sm;
        check({tag, "_busy_run"}, 64'(busy), 64'd1);
        wait_done(1, lat);
        check({tag, "_latency"}, 64'(lat), 64'd34);
        check({tag, "_product"}, product, exp);
        check({tag, "_busy_done"}, 64'(busy), 64'd0);
        @(negedge clk);
        check({tag, "_done_pulse"}, 64'(done), 64'd0);
        check({tag, "_product_hold"}, product, exp);
    endtask

    initial begin
        int lat;
        int d0;

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_product", product, 64'd0);

        // rst and start together: rst wins
        start = 1'b1; a = 32'd5; b = 32'd5;
        @(posedge clk);
        @(negedge clk);
        check("rst_vs_start_busy", 64'(busy), 64'd0);
        start = 1'b0; rst = 1'b0;
        @(negedge clk);
        check("idle_busy", 64'(busy), 64'd0);

        // Test 1: unsigned max*max
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, "t1_umax");
        // Test 2: signed
        run_op(32'hFFFF_FFFD, 32'h0000_0005, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, "t2_neg3x5");
        run_op(32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, "t2_minxmin");
        // Test 3: mode contrast
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b1, 64'hFFFF_FFFF_FFFF_FFFE, "t3_signed");
        run_op(32'hFFFF_FFFF, 32'h0000_0002, 1'b0, 64'h0000_0001_FFFF_FFFE, "t3_unsigned");
        // Zero operand: no early-out
        run_op(32'h0000_0000, 32'h1234_5678, 1'b0, 64'd0, "zero_a");

        // Test 4: start while busy is dropped
        d0 = done_cnt;
        @(negedge clk);
        a = 32'd7; b = 32'd6; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
        end
        check("t4_product_during_run", product, 64'd0);
        a = 32'd9; b = 32'd9; start = 1'b1;
        @(posedge clk);
        lat++;
        @(negedge clk);
        start = 1'b0;
        wait_done(lat, lat);
        check("t4_latency", 64'(lat), 64'd34);
        check("t4_product", product, 64'h2A);
        repeat (40) @(negedge clk);
        check("t4_done_count", 64'(done_cnt - d0), 64'd1);
        check("t4_idle_busy", 64'(busy), 64'd0);
        check("t4_product_hold", product, 64'h2A);

        // Test 5: back-to-back with start held through DONE
        a = 32'd5; b = 32'd7; signed_mode = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        a = 32'd3; b = 32'd4;
        wait_done(1, lat);
        check("t5_first_latency", 64'(lat), 64'd34);
        check("t5_first_product", product, 64'h23);
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        check("t5_second_accepted", 64'(busy), 64'd1);
        check("t5_done_single", 64'(done), 64'd0);
        check("t5_product_held", product, 64'h23);
        wait_done(1, lat);
        check("t5_second_latency", 64'(lat), 64'd34);
        check("t5_second_product", product, 64'h0C);

        // Test 6: asynchronous reset mid-run
        @(negedge clk);
        a = 32'd11; b = 32'd13; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        repeat (14) @(negedge clk);
        d0 = done_cnt;
        #2 rst = 1'b1;
        #1;
        check("t6_rst_busy", 64'(busy), 64'd0);
        check("t6_rst_done", 64'(done), 64'd0);
        check("t6_rst_product", product, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        check("t6_no_done", 64'(done_cnt - d0), 64'd0);
        run_op(32'd2, 32'd3, 1'b0, 64'd6, "t6_after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
